// File: rtl/seq_divider.sv
// Sequential unsigned divider: restoring shift-subtract, one quotient bit
// per clock, MSB first. A zero divisor skips the iteration and reports
// quotient = all ones, remainder = low dividend bits, dbz = 1.
module seq_divider #(
    parameter int N = 8,
    parameter int M = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [M-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [M-1:0] remainder,
    output logic         dbz
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Working registers: r_acc holds the not-yet-consumed dividend bits in
    // its upper part and the quotient bits generated so far in its lower part.
    logic [N-1:0]  r_acc;
    logic [M-1:0]  r_dvs;
    logic [M-1:0]  r_prem;
    logic [CW-1:0] r_cnt;
    logic          r_zero;

    // Architectural results, only updated when a division completes.
    logic [N-1:0]  r_quotient;
    logic [M-1:0]  r_remainder;
    logic          r_dbz;
    logic          r_done;

    logic          w_accept;
    logic          w_load_run;
    logic          w_load_zero;
    logic [M:0]    w_part;
    logic          w_ge;
    logic [M-1:0]  w_diff;
    logic [M-1:0]  w_rem_nxt;
    logic [N-1:0]  w_acc_nxt;

    // One restoring step: bring down the next dividend bit and try to subtract.
    // When the trial succeeds the difference is below the divisor, so the low
    // M bits of the subtraction are exact.
    always_comb begin
        w_part    = {r_prem, r_acc[N-1]};
        w_ge      = (w_part >= {1'b0, r_dvs});
        w_diff    = w_part[M-1:0] - r_dvs;
        w_rem_nxt = w_ge ? w_diff : w_part[M-1:0];
        w_acc_nxt = {r_acc[N-2:0], w_ge};
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and load strobes. The zero-divisor path spends its first
    // DONE cycle loading the fixed result, then pulses done on the second.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_load_run  = 1'b0;
        w_load_zero = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = (divisor == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (r_cnt == CW'(N - 1)) begin
                    w_load_run  = 1'b1;
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (r_done) begin
                    w_state_nxt = IDLE;
                end else if (r_zero) begin
                    w_load_zero = 1'b1;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Iteration control: counter and captured zero-divisor flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_zero <= 1'b0;
        end else if (w_accept) begin
            r_cnt  <= '0;
            r_zero <= (divisor == '0);
        end else if (r_state == RUN) begin
            r_cnt  <= r_cnt + CW'(1);
        end
    end

    // Operand capture and shift-subtract datapath.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_acc  <= dividend;
            r_dvs  <= divisor;
            r_prem <= '0;
        end else if (r_state == RUN) begin
            r_acc  <= w_acc_nxt;
            r_prem <= w_rem_nxt;
        end
    end

    // Result registers and done pulse; results change only alongside done.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_load_run) begin
                r_quotient  <= w_acc_nxt;
                r_remainder <= w_rem_nxt;
                r_dbz       <= 1'b0;
                r_done      <= 1'b1;
            end else if (w_load_zero) begin
                r_quotient  <= '1;
                r_remainder <= r_acc[M-1:0];
                r_dbz       <= 1'b1;
                r_done      <= 1'b1;
            end
        end
    end

    assign busy      = (r_state == RUN);
    assign done      = r_done;
    assign quotient  = r_quotient;
    assign remainder = r_remainder;
    assign dbz       = r_dbz;

endmodule
